period_meter: RTL and testbench
===============================

# period_meter

Measures the interval, in `clock` cycles, between rising edges of a pulse input such as a divided-down audio frame strobe. It is the receiving end of the tick-generator interface: a divider with terminal count `max` produces a period of `max`+1 clocks, and this block recovers that period, reports it through a valid/ack handshake, and flags lock when it matches the expected `max`. It sits between external or cross-module strobes and the control logic that checks sample-rate timing.

## Interface

- `width`, 31, MSB index of the counter and period; all counts are `width`+1 bits.
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `tick`  in  1  pulse or level input; may be asynchronous; synchronized internally.
- `max`  in  [width:0]  expected terminal count; expected period is `max`+1.
- `ack`  in  1  consumer accepts the current `period`; acts only while `valid`=1.
- `period`  out  [width:0]  latest measured interval in clocks.
- `valid`  out  1  `period` holds unconsumed data.
- `overrun`  out  1  one or more measurements were overwritten before being acked.
- `timeout`  out  1  the counter saturated with no edge.
- `locked`  out  1  two consecutive periods equalled `max`+1.

## Operation

- **Synchronizer**
  - `tick` passes through two flops, `s1` then `s2`, then a history flop `s3`.
  - `edge` = `s2` & ~`s3`.
  - All three flops reset to 0. A `tick` held high across reset deassertion therefore yields one edge.
- **State IDLE** (the reset state)
  - Waits for the first `edge`.
  - On `edge`: count <= 1, go to MEASURE. No period is produced.
- **State MEASURE**
  - Non-edge cycle: count <= count+1. The count saturates at all-ones and never wraps. Reaching all-ones sets `timeout`.
  - Edge cycle: `period` <= count, then count <= 1, and `timeout` <= 0. Edges N clocks apart capture exactly N.
  - A capture made while saturated stores all-ones.
- **Handshake**
  - A capture sets `valid`.
  - `ack`=1 while `valid`=1 and no edge arrives: `valid` <= 0 and `overrun` <= 0 on the next clock.
  - Capture while `valid`=1 and `ack`=0: `period` is overwritten with the new value, `valid` stays 1, and `overrun` <= 1.
  - Capture and `ack` in the same cycle: the old data is consumed and the new data loaded. `valid` stays 1 and `overrun` <= 0.
  - `ack` while `valid`=0 is ignored.
- **Lock**
  - On each capture, compare the captured value with `max`+1, computed at width+1 bits. If `max` is all-ones, `max`+1 wraps to 0 and never matches.
  - Keep a 1-bit "previous capture matched" flag.
  - `locked` <= match & prev_match.
  - Any mismatching capture, or `timeout` rising, clears `locked` and the flag.
  - `max` is sampled at capture time. Changing it mid-measurement affects only the next capture.
- **Reset mid-operation**
  - Returns to IDLE and clears count, flags, and synchronizer.
  - The next edge is treated as a first edge.

## Timing

- Reset values: `period`=0, `valid`=0, `overrun`=0, `timeout`=0, `locked`=0. The state is IDLE and count=0.
- `tick` sampled high at clock edge E0 gives `s2`=1 after E1 and `edge` during the following cycle.
- `period`, `valid`, and `locked` update at E2, two clocks after the sampling edge. This latency is constant, so measured intervals are exact.
- The minimum resolvable period is 2 clocks, which requires `tick` low for at least 1 sampled cycle between highs. A `tick` level held high counts as one edge.
- `valid` falls one clock after the accepting `ack` edge.
- `timeout` asserts on the clock where count becomes all-ones. With `width`=7, that is 254 clocks after the last edge with no new edge.
- All outputs are registered, with no combinational paths from inputs to outputs.

## Test plan

- **Reset:** hold `reset` 3 cycles with `tick` toggling.
  - During reset and the cycle after: all outputs 0.
  - The first edge after reset produces no `valid`.
- **Nominal:** `max`=47, `tick` 1-cycle high every 48 clocks, `ack` pulsed 1 cycle after each `valid`.
  - Second edge: `period`=48, `valid`=1, `locked`=0.
  - Third edge: `period`=48, `locked`=1.
  - Then step `max` to 63: `locked`=0 after the next capture.
- **Overrun:** `tick` every 10 clocks, `ack` held 0 for three captures.
  - `period`=10, `valid`=1, `overrun`=1.
  - A single `ack` then gives `valid`=0 and `overrun`=0.
- **Simultaneous:** assert `ack` on the exact cycle of the next capture.
  - `valid` stays 1, `period` holds the new value, `overrun`=0.
- **Timeout:** `width`=7, stop `tick` for 400 clocks.
  - `timeout`=1 and `locked`=0.
  - Next edge: `period`=255, `timeout`=0.
  - Following 20-clock interval: `period`=20.
- **Reset mid-measure:** `reset` 1 cycle, 5 clocks after an edge, with a 30-clock `tick` cadence.
  - The next edge gives no `valid`.
  - The edge after that gives `period`=30.

Source files
------------

// File: rtl/period_meter_if.sv
// ============================================================================
// Module   : period_meter_if
// Brief    : Strobe input, expected count and period/handshake/status bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface period_meter_if #(
  parameter int width = 31
);
  logic           tick;
  logic [width:0] max;
  logic           ack;
  logic [width:0] period;
  logic           valid;
  logic           overrun;
  logic           timeout;
  logic           locked;

  // master is the meter itself; slave is the strobe source / period consumer
  modport master (
    input  tick, max, ack,
    output period, valid, overrun, timeout, locked
  );

  modport slave (
    output tick, max, ack,
    input  period, valid, overrun, timeout, locked
  );
endinterface

`default_nettype wire

// File: rtl/period_meter.sv
// ============================================================================
// Module   : period_meter
// Brief    : Measures clocks between rising edges of tick, reports via
//            valid/ack, flags overrun, timeout and lock against max+1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module period_meter #(
  parameter int width = 31
) (
  input  wire logic      clock,
  input  wire logic      reset,
  period_meter_if.master bus
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  localparam logic [width:0] c_all_ones = '1;
  localparam logic [width:0] c_one      = {{width{1'b0}}, 1'b1};

  state_t         r_state;
  logic           r_s1;
  logic           r_s2;
  logic           r_s3;
  logic [width:0] r_count;
  logic [width:0] r_period;
  logic           r_valid;
  logic           r_overrun;
  logic           r_timeout;
  logic           r_locked;
  logic           r_prev_match;

  logic           w_edge;
  logic           w_capture;
  logic           w_match;
  logic [width:0] w_target;
  logic [width:0] w_count_inc;

  assign w_edge      = r_s2 & ~r_s3;
  assign w_capture   = (r_state == ST_MEASURE) & w_edge;
  // max of all-ones wraps the target to 0, which a capture can never equal
  assign w_target    = bus.max + c_one;
  assign w_match     = (r_count == w_target);
  assign w_count_inc = r_count + c_one;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_count      <= '0;
      r_period     <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
      r_locked     <= 1'b0;
      r_prev_match <= 1'b0;
    end else begin
      r_s1 <= bus.tick;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      if (r_valid && bus.ack && !w_capture) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_edge) begin
            r_count <= c_one;
            r_state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_edge) begin
            r_period     <= r_count;
            r_count      <= c_one;
            r_timeout    <= 1'b0;
            r_valid      <= 1'b1;
            // an ack in the capture cycle consumes the old data first
            r_overrun    <= r_valid & ~bus.ack;
            r_locked     <= w_match & r_prev_match;
            r_prev_match <= w_match;
          end else if (r_count != c_all_ones) begin
            r_count <= w_count_inc;
            if (w_count_inc == c_all_ones) begin
              r_timeout    <= 1'b1;
              r_locked     <= 1'b0;
              r_prev_match <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.period  = r_period;
  assign bus.valid   = r_valid;
  assign bus.overrun = r_overrun;
  assign bus.timeout = r_timeout;
  assign bus.locked  = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_period_meter.sv
// ============================================================================
// Module   : tb_period_meter
// Brief    : Scoreboard bench for period_meter with an 8-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_period_meter;

  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  period_meter_if #(.width(7)) bus ();

  period_meter #(.width(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] per;
    logic       ovr;
    logic       lck;
  } exp_t;

  exp_t sb[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Pulse tick for one cycle at the current negedge, queue the capture it
  // should cause, and return at the first negedge where that capture shows.
  task automatic send_tick(input logic [7:0] per, input logic ovr,
                           input logic lck, input logic simul_ack);
    exp_t x;
    x.per = per;
    x.ovr = ovr;
    x.lck = lck;
    sb.push_back(x);
    bus.tick = 1'b1;
    @(negedge clock);
    bus.tick = 1'b0;
    @(negedge clock);
    if (simul_ack) bus.ack = 1'b1;
    @(negedge clock);
    bus.ack = 1'b0;
  endtask

  task automatic ack_pulse;
    bus.ack = 1'b1;
    @(negedge clock);
    bus.ack = 1'b0;
  endtask

  task automatic test_reset;
    bus.ack  = 1'b0;
    bus.max  = 8'd47;
    bus.tick = 1'b0;
    reset    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      bus.tick = ~bus.tick;
      checks++;
      if ({bus.period, bus.valid, bus.overrun, bus.timeout, bus.locked} !== 12'h000) begin
        failures++;
        $display("FAIL reset_hold[%0d]: got %h expected 000", i,
                 {bus.period, bus.valid, bus.overrun, bus.timeout, bus.locked});
      end
    end
    reset    = 1'b0;
    bus.tick = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.period, bus.valid, bus.overrun, bus.timeout, bus.locked} !== 12'h000) begin
      failures++;
      $display("FAIL reset_after: got %h expected 000",
               {bus.period, bus.valid, bus.overrun, bus.timeout, bus.locked});
    end
    // first edge only arms the counter
    bus.tick = 1'b1;
    @(negedge clock);
    bus.tick = 1'b0;
    idle(2);
    checks++;
    if ({bus.valid, bus.period} !== 9'h000) begin
      failures++;
      $display("FAIL first_edge_no_valid: got valid/period %h expected 000", {bus.valid, bus.period});
    end
    idle(45);
  endtask

  task automatic test_nominal;
    exp_t e;
    int   gap;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.max = 8'd63;
      send_tick(8'd48, 1'b0, (i == 1), 1'b0);
      e = sb.pop_front();
      checks++;
      if ({bus.period, bus.valid, bus.overrun, bus.locked, bus.timeout} !== {e.per, 1'b1, e.ovr, e.lck, 1'b0}) begin
        failures++;
        $display("FAIL nominal_capture[%0d]: got per/v/ovr/lck/tmo %h expected %h", i,
                 {bus.period, bus.valid, bus.overrun, bus.locked, bus.timeout},
                 {e.per, 1'b1, e.ovr, e.lck, 1'b0});
      end
      ack_pulse();
      checks++;
      if (bus.valid !== 1'b0) begin
        failures++;
        $display("FAIL nominal_ack[%0d]: got valid %b expected 0", i, bus.valid);
      end
      gap = (i < 2) ? 48 : 10;
      idle(gap - 4);
    end
  endtask

  task automatic test_overrun;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      send_tick(8'd10, (i > 0), 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({bus.period, bus.valid, bus.overrun, bus.locked, bus.timeout} !== {e.per, 1'b1, e.ovr, e.lck, 1'b0}) begin
        failures++;
        $display("FAIL overrun_capture[%0d]: got per/v/ovr/lck/tmo %h expected %h", i,
                 {bus.period, bus.valid, bus.overrun, bus.locked, bus.timeout},
                 {e.per, 1'b1, e.ovr, e.lck, 1'b0});
      end
      if (i < 2) idle(7);
    end
    ack_pulse();
    checks++;
    if ({bus.valid, bus.overrun} !== 2'b00) begin
      failures++;
      $display("FAIL overrun_ack: got valid/overrun %b expected 00", {bus.valid, bus.overrun});
    end
    idle(6);
  endtask

  task automatic test_simultaneous;
    exp_t          e;
    logic [7:0]    pers [3];
    logic [2:0]    ovrs;
    logic [2:0]    lcks;
    pers = '{8'd10, 8'd13, 8'd13};
    ovrs = 3'b010;
    lcks = 3'b100;
    bus.max = 8'd12;
    for (int i = 0; i < 3; i++) begin
      send_tick(pers[i], ovrs[i], lcks[i], (i == 2));
      e = sb.pop_front();
      checks++;
      if ({bus.period, bus.valid, bus.overrun, bus.locked, bus.timeout} !== {e.per, 1'b1, e.ovr, e.lck, 1'b0}) begin
        failures++;
        $display("FAIL simul_capture[%0d]: got per/v/ovr/lck/tmo %h expected %h", i,
                 {bus.period, bus.valid, bus.overrun, bus.locked, bus.timeout},
                 {e.per, 1'b1, e.ovr, e.lck, 1'b0});
      end
      if (i < 2) idle(10);
    end
  endtask

  task automatic test_timeout;
    exp_t e;
    idle(253);
    checks++;
    if (bus.timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: got %b expected 0", bus.timeout);
    end
    idle(1);
    checks++;
    if ({bus.timeout, bus.locked} !== 2'b10) begin
      failures++;
      $display("FAIL timeout_set: got timeout/locked %b expected 10", {bus.timeout, bus.locked});
    end
    idle(143);
    for (int i = 0; i < 2; i++) begin
      send_tick((i == 0) ? 8'd255 : 8'd20, (i == 0), 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({bus.period, bus.valid, bus.overrun, bus.locked, bus.timeout} !== {e.per, 1'b1, e.ovr, e.lck, 1'b0}) begin
        failures++;
        $display("FAIL timeout_capture[%0d]: got per/v/ovr/lck/tmo %h expected %h", i,
                 {bus.period, bus.valid, bus.overrun, bus.locked, bus.timeout},
                 {e.per, 1'b1, e.ovr, e.lck, 1'b0});
      end
      ack_pulse();
      idle((i == 0) ? 16 : 26);
    end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      send_tick(8'd30, 1'b0, 1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({bus.period, bus.valid, bus.overrun, bus.locked, bus.timeout} !== {e.per, 1'b1, e.ovr, e.lck, 1'b0}) begin
        failures++;
        $display("FAIL mid_capture[%0d]: got per/v/ovr/lck/tmo %h expected %h", i,
                 {bus.period, bus.valid, bus.overrun, bus.locked, bus.timeout},
                 {e.per, 1'b1, e.ovr, e.lck, 1'b0});
      end
      ack_pulse();
      if (i == 1) break;
      idle(1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checks++;
      if ({bus.period, bus.valid, bus.overrun, bus.timeout, bus.locked} !== 12'h000) begin
        failures++;
        $display("FAIL mid_reset_clear: got %h expected 000",
                 {bus.period, bus.valid, bus.overrun, bus.timeout, bus.locked});
      end
      idle(24);
      bus.tick = 1'b1;
      @(negedge clock);
      bus.tick = 1'b0;
      idle(2);
      checks++;
      if (bus.valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_first_edge: got valid %b expected 0", bus.valid);
      end
      idle(27);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overrun();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
